// File: rtl/instr_rom_loader.sv
// ---------------------------------------------------------------------------
// instr_rom_loader
//
// Purpose:
//   Turns a byte stream carrying a little-endian program image into 32-bit
//   instruction-memory writes. Bytes are packed four at a time. A completed
//   word of all zeros ends the load. A partial word that carries in_last is
//   zero-filled and written if it is nonzero. The load also ends when the
//   memory is full. When the load ends, rom_size reports the image size in
//   bytes. A restart pulse in DONE begins a fresh load.
//
// Parameters:
//   MAX_WORDS  instruction memory capacity in 32-bit words (power of two, >= 2)
//
// Ports:
//   clk        single clock, rising-edge active
//   reset      asynchronous, active-high reset
//   in_valid   stream byte valid
//   in_byte    stream byte (file byte order)
//   in_last    final byte of the stream, qualified by in_valid
//   in_ready   loader accepts a byte this cycle (high in LOAD)
//   restart    begin a new load (honoured only in DONE)
//   wr_en      one-cycle instruction-memory write strobe
//   wr_addr    word index of the write
//   wr_data    assembled instruction word
//   rom_size   loaded program size in bytes, valid while load_done=1
//   load_done  load finished; memory contents and rom_size are final
// ---------------------------------------------------------------------------
module instr_rom_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [7:0]                   in_byte,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic                         restart,
    output logic                         wr_en,
    output logic [$clog2(MAX_WORDS)-1:0] wr_addr,
    output logic [31:0]                  wr_data,
    output logic [31:0]                  rom_size,
    output logic                         load_done
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_WORDS);

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    lane;
    logic [23:0]   partial;
    logic [CW-1:0] word_count;

    logic          accept;
    logic          completes;
    logic [31:0]   word_next;
    logic [CW-1:0] count_inc;

    // Size in bytes of a program holding n words.
    function automatic logic [31:0] bytes_of(input logic [CW-1:0] n);
        return 32'({n, 2'b00});
    endfunction

    assign in_ready = (state == LOAD);

    // Builds the word that would result if the current byte completed it.
    // Lanes not yet filled read as zero, which gives the zero-fill for a
    // short final word.
    always_comb begin
        accept    = in_valid && (state == LOAD);
        completes = (lane == 2'd3) || in_last;
        count_inc = word_count + 1'b1;
        word_next = 32'h0;
        case (lane)
            2'd0: word_next = {24'h0, in_byte};
            2'd1: word_next = {16'h0, in_byte, partial[7:0]};
            2'd2: word_next = {8'h0, in_byte, partial[15:0]};
            2'd3: word_next = {in_byte, partial[23:0]};
            default: word_next = 32'h0;
        endcase
    end

    // Loader FSM. All outputs are registered here. wr_en defaults low every
    // cycle, so it pulses for exactly one cycle after a word-completing
    // handshake. wr_addr and wr_data hold their last values between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            lane       <= 2'd0;
            partial    <= 24'h0;
            word_count <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'h0;
            rom_size   <= 32'h0;
            load_done  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (completes) begin
                            lane    <= 2'd0;
                            partial <= 24'h0;
                            if (word_next == 32'h0) begin
                                // Terminator word: end the load and do not write.
                                state     <= DONE;
                                load_done <= 1'b1;
                                rom_size  <= bytes_of(word_count);
                            end else begin
                                wr_en      <= 1'b1;
                                wr_addr    <= word_count[AW-1:0];
                                wr_data    <= word_next;
                                word_count <= count_inc;
                                // End of stream or memory now full.
                                if (in_last || (count_inc == FULL_COUNT)) begin
                                    state     <= DONE;
                                    load_done <= 1'b1;
                                    rom_size  <= bytes_of(count_inc);
                                end
                            end
                        end else begin
                            case (lane)
                                2'd0:    partial[7:0]   <= in_byte;
                                2'd1:    partial[15:8]  <= in_byte;
                                default: partial[23:16] <= in_byte;
                            endcase
                            lane <= lane + 2'd1;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        state      <= LOAD;
                        lane       <= 2'd0;
                        partial    <= 24'h0;
                        word_count <= '0;
                        rom_size   <= 32'h0;
                        load_done  <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_rom_loader
//
// Purpose:
//   Self-checking bench for instr_rom_loader. The stimulus process pushes each
//   expected memory write into a queue before it drives the bytes. A monitor
//   process pops from the queue and compares on every wr_en cycle. Status
//   outputs (load_done, rom_size, in_ready) are checked directly against
//   constants computed by hand.
// ---------------------------------------------------------------------------
module tb_instr_rom_loader;

    localparam int MAX_WORDS = 256;
    localparam int AW        = $clog2(MAX_WORDS);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_last;
    logic          in_ready;
    logic          restart;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rom_size;
    logic          load_done;

    int assertCount = 0;
    int failCount   = 0;

    // Expected writes: {address, data}.
    logic [AW+31:0] expectQ[$];

    instr_rom_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .restart   (restart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rom_size  (rom_size),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one value against its expected value and records the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers one byte for a single cycle, then idles for gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input logic last, input int gap);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends a word as four bytes, least significant byte first.
    task automatic sendWord(input logic [31:0] w, input logic lastOnFinal, input int gap);
        applyStimulus(w[7:0],   1'b0, gap);
        applyStimulus(w[15:8],  1'b0, gap);
        applyStimulus(w[23:16], 1'b0, gap);
        applyStimulus(w[31:24], lastOnFinal, gap);
    endtask

    task automatic pushWrite(input int addr, input logic [31:0] data);
        expectQ.push_back({AW'(addr), data});
    endtask

    // Pulses restart for one cycle and checks that the loader is back in LOAD.
    task automatic pulseRestart(input string tag);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checkOutput({tag, "_load_done_cleared"}, 32'(load_done), 32'd0);
        checkOutput({tag, "_rom_size_cleared"},  rom_size,        32'd0);
        checkOutput({tag, "_in_ready_set"},      32'(in_ready),   32'd1);
    endtask

    task automatic checkDone(input string tag, input logic [31:0] size);
        checkOutput({tag, "_load_done"}, 32'(load_done), 32'd1);
        checkOutput({tag, "_rom_size"},  rom_size,        size);
        checkOutput({tag, "_in_ready"},  32'(in_ready),   32'd0);
    endtask

    // Monitor: each wr_en cycle must match the next expected write.
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (expectQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, expected no write",
                         wr_addr, wr_data);
            end else begin
                logic [AW+31:0] exp;
                exp = expectQ.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(exp[AW+31:32]));
                checkOutput("wr_data", wr_data, exp[31:0]);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        restart  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_wr_en",     32'(wr_en),     32'd0);
        checkOutput("reset_wr_addr",   32'(wr_addr),   32'd0);
        checkOutput("reset_wr_data",   wr_data,        32'd0);
        checkOutput("reset_rom_size",  rom_size,       32'd0);
        checkOutput("reset_load_done", 32'(load_done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back word then terminator");
        pushWrite(0, 32'h00A00513);
        sendWord(32'h00A00513, 1'b0, 0);
        checkOutput("b2b_not_done_early", 32'(load_done), 32'd0);
        sendWord(32'h00000000, 1'b0, 0);
        checkDone("b2b", 32'd4);

        pulseRestart("r1");
        $display("[TB] same stream with 3 idle cycles between bytes");
        pushWrite(0, 32'h00A00513);
        sendWord(32'h00A00513, 1'b0, 3);
        sendWord(32'h00000000, 1'b0, 3);
        checkDone("gap", 32'd4);

        pulseRestart("r2");
        $display("[TB] full word then short in_last word, restart ignored in LOAD");
        pushWrite(0, 32'h00A00513);
        pushWrite(1, 32'h00000093);
        sendWord(32'h00A00513, 1'b0, 0);
        applyStimulus(8'h93, 1'b0, 0);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        checkOutput("restart_in_load_ready", 32'(in_ready), 32'd1);
        applyStimulus(8'h00, 1'b1, 0);
        checkDone("short", 32'd8);

        pulseRestart("r3");
        $display("[TB] reset mid-word discards partial word");
        applyStimulus(8'h13, 1'b0, 0);
        applyStimulus(8'h05, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_wr_en", 32'(wr_en), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pushWrite(0, 32'h00000093);
        sendWord(32'h00000093, 1'b0, 0);
        sendWord(32'h00000000, 1'b0, 0);
        checkDone("midreset", 32'd4);

        pulseRestart("r4");
        $display("[TB] fill memory with %0d words", MAX_WORDS);
        for (int i = 0; i < MAX_WORDS; i++) begin
            logic [31:0] w;
            w = 32'hC0DE0000 + 32'(i);
            pushWrite(i, w);
            sendWord(w, 1'b0, 0);
        end
        checkDone("full", 32'd1024);
        applyStimulus(8'h11, 1'b0, 0);
        applyStimulus(8'h22, 1'b0, 0);
        applyStimulus(8'h33, 1'b0, 0);
        applyStimulus(8'h44, 1'b0, 0);
        checkDone("full_extra", 32'd1024);

        pulseRestart("r5");
        $display("[TB] reload two words, terminator carries in_last");
        pushWrite(0, 32'h12345678);
        pushWrite(1, 32'hDEADBEEF);
        sendWord(32'h12345678, 1'b0, 0);
        checkOutput("reload_done_low", 32'(load_done), 32'd0);
        sendWord(32'hDEADBEEF, 1'b0, 1);
        sendWord(32'h00000000, 1'b1, 0);
        checkDone("reload", 32'd8);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("pending_writes", 32'(expectQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_rom_loader.md
INSTR_ROM_LOADER -- requirements
Module: instr_rom_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning instruction memory capacity in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  byte-stream valid.
REQ-005 SHALL have port in_byte  input  8  stream byte, program image in file byte order (little-endian instructions).
REQ-006 SHALL have port in_last  input  1  marks final byte of stream; qualified by in_valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port restart  input  1  synchronous request to begin a new load from DONE.
REQ-009 SHALL have port wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  log2(MAX_WORDS)  word index of write.
REQ-011 SHALL have port wr_data  output  32  assembled instruction word.
REQ-012 SHALL have port rom_size  output  32  loaded program size in bytes, valid when load_done=1.
REQ-013 SHALL have port load_done  output  1  load finished; memory contents and rom_size final.

Function
REQ-014 SHALL implement two states: LOAD and DONE; in_ready = 1 in LOAD, 0 in DONE (combinational from state).
REQ-015 SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1; no other cycle changes the byte lane count.
REQ-016 SHALL place accepted bytes 0..3 of each word into wr_data bits [7:0], [15:8], [23:16], [31:24] respectively.
REQ-017 SHALL, on the edge accepting byte 3 of a nonzero word, register wr_en=1, wr_addr=word_count, wr_data=assembled word, and increment word_count; wr_en is therefore high exactly the cycle after that handshake.
REQ-018 SHALL deassert wr_en on every cycle not covered by REQ-017/REQ-020; wr_addr and wr_data hold their last values.
REQ-019 SHALL treat a completed word equal to 0x00000000 as terminator: no write, word_count unchanged, transition to DONE.
REQ-020 SHALL, on an accepted byte with in_last=1 that does not complete a word, zero-fill remaining upper bytes and write the word per REQ-017 if nonzero; it SHALL then enter DONE regardless.
REQ-021 SHALL, when a write brings word_count to MAX_WORDS, enter DONE on the same edge (full); no further bytes accepted.
REQ-022 SHALL, on entering DONE, register rom_size = 4 x final word_count and load_done=1 on the same edge.
REQ-023 SHALL, in DONE with restart=1, clear word_count, byte lane, rom_size, load_done and return to LOAD next cycle; restart in LOAD is ignored.
REQ-024 SHALL keep word_count wide enough to hold MAX_WORDS (log2(MAX_WORDS)+1 bits); wr_addr never wraps.
REQ-025 SHALL give in_last priority only for the byte it accompanies; terminator detection (REQ-019) and in_last on the same byte yield one DONE entry, no write.

Reset
REQ-026 SHALL, while reset=1, force state LOAD, byte lane 0, word_count 0, wr_en 0, wr_addr 0, wr_data 0, rom_size 0, load_done 0; in_ready reads 1.
REQ-027 SHALL discard any partially assembled word when reset asserts mid-word; no write results from it.

Verification
REQ-028 SHALL pass: bytes 13 05 A0 00, 00 00 00 00 back-to-back -> one wr_en cycle, wr_addr 0, wr_data 0x00A00513; then load_done=1, rom_size=4, in_ready=0.
REQ-029 SHALL pass: same stream with in_valid low 3 cycles between every byte -> identical writes and rom_size=4; wr_en exactly one cycle.
REQ-030 SHALL pass: 256 nonzero words, no terminator -> last write wr_addr 255; load_done=1, rom_size=1024, in_ready=0 next cycle, extra bytes ignored.
REQ-031 SHALL pass: one full word 0x00A00513 then bytes 93 00 with in_last on second -> writes addr0 0x00A00513, addr1 0x00000093; rom_size=8.
REQ-032 SHALL pass: reset asserted after 2 bytes of word 1, then bytes 93 00 00 00, 00 00 00 00 -> single write addr 0 data 0x00000093; rom_size=4.
REQ-033 SHALL pass: in DONE pulse restart, reload 2 words + terminator -> addr 0,1 written; rom_size=8; load_done low between restart and new DONE.
